// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the traffic-light sprite blitter:
// FSM states, sprite geometry, lens windows and the RGB888 palette.
package traffic_light_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DRAW,
      FLUSH,
      DONE
   } state_t;

   localparam int SPRITE_DIM = 40;
   localparam logic [5:0] SPRITE_MAX = 6'(SPRITE_DIM - 1);

   // Lens windows in sprite coordinates (inclusive bounds)
   localparam logic [5:0] RED_ROW_LO  = 6'd4;
   localparam logic [5:0] RED_ROW_HI  = 6'd15;
   localparam logic [5:0] GRN_ROW_LO  = 6'd19;
   localparam logic [5:0] GRN_ROW_HI  = 6'd30;
   localparam logic [5:0] LENS_COL_LO = 6'd2;
   localparam logic [5:0] LENS_COL_HI = 6'd37;

   localparam logic [23:0] HOUSING   = 24'h303030;
   localparam logic [23:0] RED_LIT   = 24'hFF0000;
   localparam logic [23:0] RED_DIM   = 24'h400000;
   localparam logic [23:0] GREEN_LIT = 24'h00FF00;
   localparam logic [23:0] GREEN_DIM = 24'h004000;

   function automatic logic in_range(
      input logic [5:0] v,
      input logic [5:0] lo,
      input logic [5:0] hi
   );
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/traffic_light_color_sel.sv
// Combinational lens/housing colour lookup for one sprite coordinate.
// In: sx, sy (sprite column/row), light (bit0 red lit, bit1 green lit). Out: color RGB888.
module traffic_light_color_sel
   import traffic_light_pkg::*;
(
   input  logic [5:0]  sx,
   input  logic [5:0]  sy,
   input  logic [1:0]  light,
   output logic [23:0] color
);

   logic in_col;
   logic red_row;
   logic grn_row;

   assign in_col  = in_range(sx, LENS_COL_LO, LENS_COL_HI);
   assign red_row = in_range(sy, RED_ROW_LO, RED_ROW_HI);
   assign grn_row = in_range(sy, GRN_ROW_LO, GRN_ROW_HI);

   always_comb begin
      color = HOUSING;
      unique case (1'b1)
         (in_col && red_row): color = light[0] ? RED_LIT : RED_DIM;
         (in_col && grn_row): color = light[1] ? GREEN_LIT : GREEN_DIM;
         default:             color = HOUSING;
      endcase
   end

endmodule

// File: rtl/traffic_light_sprite_blitter.sv
// Scans the 40x40 traffic-light sprite ROM and writes opaque, on-screen
// pixels into the framebuffer through a one-entry valid/ready output slot.
// Ports: clk, reset (sync, active-high); start/origin_x/origin_y/light request;
// sprite_x/sprite_y -> ROM, pixel <- ROM; fb_wr_en/fb_x/fb_y/fb_color with
// fb_ready backpressure; busy (DRAW/FLUSH), done (one-cycle completion pulse).
module traffic_light_sprite_blitter
   import traffic_light_pkg::*;
#(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int X_W      = 10,
   parameter int Y_W      = 9
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [X_W-1:0] origin_x,
   input  logic [Y_W-1:0] origin_y,
   input  logic [1:0]     light,
   output logic [5:0]     sprite_x,
   output logic [5:0]     sprite_y,
   input  logic           pixel,
   output logic           fb_wr_en,
   output logic [X_W-1:0] fb_x,
   output logic [Y_W-1:0] fb_y,
   output logic [23:0]    fb_color,
   input  logic           fb_ready,
   output logic           busy,
   output logic           done
);

   localparam logic [X_W:0] X_LIM = (X_W + 1)'(SCREEN_W);
   localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(SCREEN_H);

   state_t         state;
   logic [X_W-1:0] org_x;
   logic [Y_W-1:0] org_y;
   logic [1:0]     lt;
   logic [5:0]     sx;
   logic [5:0]     sy;

   // One extra bit so origin + offset never wraps back on screen
   logic [X_W:0]   px;
   logic [Y_W:0]   py;
   logic           slot_free;
   logic           hit;
   logic           row_end;
   logic           last_pos;
   logic [23:0]    color;

   assign sprite_x = sx;
   assign sprite_y = sy;

   assign px = {1'b0, org_x} + (X_W + 1)'(sx);
   assign py = {1'b0, org_y} + (Y_W + 1)'(sy);

   assign slot_free = !fb_wr_en || fb_ready;
   assign hit       = pixel && (px < X_LIM) && (py < Y_LIM);
   assign row_end   = (sx == SPRITE_MAX);
   assign last_pos  = row_end && (sy == SPRITE_MAX);

   traffic_light_color_sel u_color (
      .sx    (sx),
      .sy    (sy),
      .light (lt),
      .color (color)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         org_x    <= '0;
         org_y    <= '0;
         lt       <= '0;
         sx       <= '0;
         sy       <= '0;
         fb_wr_en <= 1'b0;
         fb_x     <= '0;
         fb_y     <= '0;
         fb_color <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  org_x <= origin_x;
                  org_y <= origin_y;
                  lt    <= light;
                  sx    <= '0;
                  sy    <= '0;
                  busy  <= 1'b1;
                  state <= DRAW;
               end
            end
            DRAW: begin
               // A stalled slot freezes both the outputs and the scan
               if (slot_free) begin
                  if (hit) begin
                     fb_wr_en <= 1'b1;
                     fb_x     <= px[X_W-1:0];
                     fb_y     <= py[Y_W-1:0];
                     fb_color <= color;
                  end else begin
                     fb_wr_en <= 1'b0;
                  end
                  if (row_end) begin
                     sx <= '0;
                     sy <= last_pos ? 6'd0 : sy + 6'd1;
                  end else begin
                     sx <= sx + 6'd1;
                  end
                  if (last_pos) begin
                     state <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               if (slot_free) begin
                  fb_wr_en <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
